// File: rtl/irda_mode_switch_pkg.sv
// Shared IrDA definitions: switch FSM states, mode constants
// and the counter sizing helper.
package irda_mode_switch_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_BUS = 2'd1,
    DRAIN    = 2'd2,
    CORE_RST = 2'd3
  } state_t;

  localparam logic MODE_SIR  = 1'b0;
  localparam logic MODE_FAST = 1'b1;

  function automatic int cnt_width(input int d, input int r);
    int m;
    int w;
    m = (d > r) ? d : r;
    w = $clog2(m);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/irda_mode_switch.sv
// Transaction-safe fast/SIR mode switch in front of the IrDA
// Wishbone router: waits, drains, flips, then resets the new core.
module irda_mode_switch
  import irda_mode_switch_pkg::*;
#(
  parameter int DRAIN_CYCLES = 8,
  parameter int RST_CYCLES   = 4,
  parameter bit RESET_MODE   = MODE_SIR
) (
  input  logic wb_clk_i,
  input  logic wb_rst_i,
  input  logic mode_req,
  input  logic wb_cyc_i,
  input  logic wb_stb_i,
  input  logic wb_ack_i,
  output logic wb_cyc_o,
  output logic wb_stb_o,
  output logic fast_mode,
  output logic f_core_rst,
  output logic u_core_rst,
  output logic mode_busy
);

  localparam int CW = cnt_width(DRAIN_CYCLES, RST_CYCLES);
  localparam logic [CW-1:0] D_LOAD = CW'(DRAIN_CYCLES - 1);
  localparam logic [CW-1:0] R_LOAD = CW'(RST_CYCLES - 1);

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          target, target_nxt;
  logic          mode, mode_nxt;
  logic          bus_active;
  logic          gate;

  assign bus_active = wb_cyc_i & wb_stb_i;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state  <= IDLE;
      cnt    <= '0;
      target <= RESET_MODE;
      mode   <= RESET_MODE;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      target <= target_nxt;
      mode   <= mode_nxt;
    end
  end

  // One down-counter serves both the drain and core-reset windows
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    target_nxt = target;
    mode_nxt   = mode;
    unique case (state)
      IDLE: begin
        if (mode_req != mode) begin
          target_nxt = mode_req;
          if (bus_active) begin
            state_nxt = WAIT_BUS;
          end else begin
            state_nxt = DRAIN;
            cnt_nxt   = D_LOAD;
          end
        end
      end
      WAIT_BUS: begin
        if (wb_ack_i || !wb_cyc_i) begin
          state_nxt = DRAIN;
          cnt_nxt   = D_LOAD;
        end
      end
      DRAIN: begin
        if (cnt == '0) begin
          mode_nxt  = target;
          cnt_nxt   = R_LOAD;
          state_nxt = CORE_RST;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      CORE_RST: begin
        if (cnt == '0) begin
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    gate       = (state == DRAIN) || (state == CORE_RST);
    wb_cyc_o   = wb_cyc_i & ~gate;
    wb_stb_o   = wb_stb_i & ~gate;
    fast_mode  = mode;
    f_core_rst = (state == CORE_RST) &  mode;
    u_core_rst = (state == CORE_RST) & ~mode;
    mode_busy  = (state != IDLE);
  end

endmodule

// File: tb/tb_irda_mode_switch.sv
// Bench for irda_mode_switch: vector table, corner sequences and
// a random run against a blocked-window reference model.
module tb_irda_mode_switch;

  localparam int D = 8;
  localparam int R = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic req = 1'b0;
  logic cyc = 1'b0;
  logic stb = 1'b0;
  logic ack = 1'b0;
  logic cyc_o, stb_o, fm, frst, urst, busy;

  int total = 0;
  int bad = 0;

  irda_mode_switch #(
    .DRAIN_CYCLES(D),
    .RST_CYCLES(R),
    .RESET_MODE(1'b0)
  ) dut (
    .wb_clk_i(clk),
    .wb_rst_i(rst),
    .mode_req(req),
    .wb_cyc_i(cyc),
    .wb_stb_i(stb),
    .wb_ack_i(ack),
    .wb_cyc_o(cyc_o),
    .wb_stb_o(stb_o),
    .fast_mode(fm),
    .f_core_rst(frst),
    .u_core_rst(urst),
    .mode_busy(busy)
  );

  always #5 clk = ~clk;

  // Model: a switch is a wait for the bus, then a blocked window of
  // D+R cycles whose last R cycles hold the reset of the new core.
  bit m_fm = 1'b0;
  bit m_tgt = 1'b0;
  bit m_pend = 1'b0;
  int m_left = 0;
  bit mon_on = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_fm = 1'b0;
      m_tgt = 1'b0;
      m_pend = 1'b0;
      m_left = 0;
    end else if (m_left > 0) begin
      m_left = m_left - 1;
      if (m_left == R) m_fm = m_tgt;
    end else if (m_pend) begin
      if (ack || !cyc) begin
        m_pend = 1'b0;
        m_left = D + R;
      end
    end else if (req != m_fm) begin
      m_tgt = req;
      if (cyc && stb) m_pend = 1'b1;
      else m_left = D + R;
    end
  end

  function automatic logic [5:0] model_out();
    bit g, rp;
    g  = (m_left > 0);
    rp = g && (m_left <= R);
    return {cyc & ~g, stb & ~g, m_fm, rp & m_fm, rp & ~m_fm,
            m_pend | g};
  endfunction

  task automatic chk(input string n, input logic [7:0] act,
                     input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b at %0t", n, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    #2;
    if (mon_on)
      chk("model", {2'b00, cyc_o, stb_o, fm, frst, urst, busy},
          {2'b00, model_out()});
  end

  task automatic step(input logic r, input logic q, input logic c,
                      input logic s, input logic a);
    @(negedge clk);
    rst = r;
    req = q;
    cyc = c;
    stb = s;
    ack = a;
    #1;
  endtask

  // Runs idle-bus cycles until the switch ends, counting core resets
  task automatic wait_idle(input logic q, output int fr, output int ur);
    bit done;
    fr = 0;
    ur = 0;
    done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      step(0, q, 0, 0, 0);
      if (frst) fr++;
      if (urst) ur++;
      if (!busy) done = 1;
    end
    if (!done) chk("idle_timeout", 8'd0, 8'd1);
  endtask

  typedef struct {
    logic       q, c, s, a;
    logic [5:0] exp;
  } vec_t;

  vec_t vt[14];
  int fr, ur;

  initial begin
    vt[0] = '{1, 0, 1, 0, 6'b010000};
    for (int i = 1; i <= 8; i++) vt[i] = '{1, 1, 1, 0, 6'b000001};
    for (int i = 9; i <= 12; i++) vt[i] = '{1, 1, 1, 0, 6'b001101};
    vt[13] = '{1, 1, 1, 0, 6'b111000};

    step(1, 0, 1, 1, 0);
    step(0, 0, 1, 1, 0);
    mon_on = 1'b1;
    chk("reset", {2'b00, cyc_o, stb_o, fm, frst, urst, busy},
        8'b00110000);

    for (int i = 0; i < 14; i++) begin
      step(0, vt[i].q, vt[i].c, vt[i].s, vt[i].a);
      chk($sformatf("vec%0d", i),
          {2'b00, cyc_o, stb_o, fm, frst, urst, busy},
          {2'b00, vt[i].exp});
    end

    // Read in flight: ack three cycles after the request
    step(0, 0, 1, 1, 0);
    chk("bus_idle_state", {7'd0, busy}, 8'd0);
    step(0, 0, 1, 1, 0);
    chk("wait_open", {5'd0, busy, stb_o, fm}, 8'b111);
    step(0, 0, 1, 1, 0);
    step(0, 0, 1, 1, 1);
    chk("ack_pass", {5'd0, busy, stb_o, cyc_o}, 8'b111);
    step(0, 0, 1, 1, 0);
    chk("post_ack_gate", {5'd0, cyc_o, stb_o, fm}, 8'b001);
    wait_idle(0, fr, ur);
    chk("busy_ur", 8'(ur), 8'd4);
    chk("busy_fr", 8'(fr), 8'd0);
    chk("busy_fm", {7'd0, fm}, 8'd0);

    // Master aborts in WAIT_BUS
    step(0, 1, 1, 1, 0);
    step(0, 1, 1, 1, 0);
    chk("abort_wait", {6'd0, busy, cyc_o}, 8'b11);
    step(0, 1, 0, 1, 0);
    chk("abort_cycle", {6'd0, busy, stb_o}, 8'b11);
    step(0, 1, 1, 1, 0);
    chk("abort_drain", {5'd0, busy, cyc_o, stb_o}, 8'b100);
    wait_idle(1, fr, ur);
    chk("abort_fr", 8'(fr), 8'd4);
    chk("abort_fm", {7'd0, fm}, 8'd1);

    // Request toggled back during DRAIN
    step(1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    chk("tog_start_fm", {7'd0, fm}, 8'd0);
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    wait_idle(0, fr, ur);
    chk("tog_fr", 8'(fr), 8'd4);
    chk("tog_fm", {7'd0, fm}, 8'd1);
    step(0, 0, 0, 0, 0);
    wait_idle(0, fr, ur);
    chk("tog2_ur", 8'(ur), 8'd4);
    chk("tog2_fr", 8'(fr), 8'd0);
    chk("tog2_fm", {7'd0, fm}, 8'd0);

    // Reset in the third core-reset cycle
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < D + 2; i++) step(0, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    chk("rst_cr3", {6'd0, frst, fm}, 8'b11);
    step(0, 0, 1, 1, 0);
    chk("rst_after", {2'b00, cyc_o, stb_o, fm, frst, urst, busy},
        8'b00110000);

    for (int i = 0; i < 500; i++) begin
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) < 5),
           1'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0));
      if (i % 10 != 0) req = fm;
    end

    step(0, fm, 0, 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
